// File: rtl/appr_mul_sequencer.sv
// appr_mul_sequencer
// Stage sequencer for the approximate-multiplier datapath. Walks each operand
// pair through load, LZD, exponent add, left shift, multiply, right shift and
// write, then advances the pair counter. After the last pair it flushes the
// result file. A per-stage watchdog traps a hung datapath stage into ERR.
//
// Handshake: every datapath stage is driven by an enable (valid) from this
// sequencer and answers with a done (ready). The enable is held high until
// the done is sampled high on a rising clk edge; the enable is still high in
// that sampling cycle and drops in the following cycle. Dual stages (LZD and
// SHIFT) capture each done into its own flag, so each enable drops
// independently. A done seen outside its own stage has no effect, and a done
// that is still high after its enable has dropped is harmless.
//
// dbg_state exposes the current FSM state for checkers and debug.

module appr_mul_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       lzd_a_done,
  input  logic       lzd_b_done,
  input  logic       add_done,
  input  logic       shift_a_done,
  input  logic       shift_b_done,
  input  logic       mul_done,
  input  logic       r_shift_done,
  input  logic       co,
  output logic       ld_a,
  output logic       ld_b,
  output logic       lzd_a_en,
  output logic       lzd_b_en,
  output logic       add_en,
  output logic       l_shift_a_en,
  output logic       l_shift_b_en,
  output logic       mul_en,
  output logic       r_shift_en,
  output logic       write_en,
  output logic       count_enable,
  output logic       write_file,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [3:0] dbg_state
);

  // Fixed encoding so that debug output values stay stable across edits.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_LZD    = 4'd2,
    S_ADD    = 4'd3,
    S_SHIFT  = 4'd4,
    S_MUL    = 4'd5,
    S_RSHIFT = 4'd6,
    S_WRITE  = 4'd7,
    S_NEXT   = 4'd8,
    S_FLUSH  = 4'd9,
    S_DONE   = 4'd10,
    S_ERR    = 4'd11
  } state_t;

  // Watchdog counter must hold values 0 .. TIMEOUT-1.
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t         state_q;
  state_t         state_d;
  logic           flag_a_q;
  logic           flag_b_q;
  logic           flag_a_d;
  logic           flag_b_d;
  logic [WDW-1:0] wd_q;
  logic           wd_expired;
  logic           wd_active;

  // The stage has been waiting TIMEOUT cycles once this is the current cycle.
  assign wd_expired = (wd_q == WD_LAST);

  // Stages whose wait time is bounded by the watchdog.
  assign wd_active = (state_q == S_LZD)   || (state_q == S_ADD) ||
                     (state_q == S_SHIFT) || (state_q == S_MUL) ||
                     (state_q == S_RSHIFT);

  assign dbg_state = state_q;

  // State and capture-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
    end
  end

  // Watchdog: restarts on any state change, counts while a stage waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else if (state_d != state_q) begin
      wd_q <= '0;
    end else if (wd_active) begin
      wd_q <= wd_q + WDW'(1);
    end
  end

  // Next-state and capture-flag logic. A done sampled in the expiry cycle
  // wins over the watchdog, so the done checks come before the expiry check.
  always_comb begin
    state_d  = state_q;
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        flag_a_d = 1'b0;
        flag_b_d = 1'b0;
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_LZD;
      end
      S_LZD: begin
        flag_a_d = flag_a_q | lzd_a_done;
        flag_b_d = flag_b_q | lzd_b_done;
        if (flag_a_d && flag_b_d) begin
          state_d  = S_ADD;
          flag_a_d = 1'b0;
          flag_b_d = 1'b0;
        end else if (wd_expired) begin
          state_d  = S_ERR;
          flag_a_d = 1'b0;
          flag_b_d = 1'b0;
        end
      end
      S_ADD: begin
        if (add_done) begin
          state_d = S_SHIFT;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_SHIFT: begin
        flag_a_d = flag_a_q | shift_a_done;
        flag_b_d = flag_b_q | shift_b_done;
        if (flag_a_d && flag_b_d) begin
          state_d  = S_MUL;
          flag_a_d = 1'b0;
          flag_b_d = 1'b0;
        end else if (wd_expired) begin
          state_d  = S_ERR;
          flag_a_d = 1'b0;
          flag_b_d = 1'b0;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d = S_RSHIFT;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_RSHIFT: begin
        if (r_shift_done) begin
          state_d = S_WRITE;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_WRITE: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        // co reflects the counter before this cycle's increment.
        if (co) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      default: begin
        state_d  = S_IDLE;
        flag_a_d = 1'b0;
        flag_b_d = 1'b0;
      end
    endcase
  end

  // Moore output decode from the registered state and capture flags.
  always_comb begin
    ld_a         = 1'b0;
    ld_b         = 1'b0;
    lzd_a_en     = 1'b0;
    lzd_b_en     = 1'b0;
    add_en       = 1'b0;
    l_shift_a_en = 1'b0;
    l_shift_b_en = 1'b0;
    mul_en       = 1'b0;
    r_shift_en   = 1'b0;
    write_en     = 1'b0;
    count_enable = 1'b0;
    write_file   = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    timeout_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        ld_a = 1'b1;
        ld_b = 1'b1;
      end
      S_LZD: begin
        lzd_a_en = ~flag_a_q;
        lzd_b_en = ~flag_b_q;
      end
      S_ADD: begin
        add_en = 1'b1;
      end
      S_SHIFT: begin
        l_shift_a_en = ~flag_a_q;
        l_shift_b_en = ~flag_b_q;
      end
      S_MUL: begin
        mul_en = 1'b1;
      end
      S_RSHIFT: begin
        r_shift_en = 1'b1;
      end
      S_WRITE: begin
        write_en = 1'b1;
      end
      S_NEXT: begin
        count_enable = 1'b1;
      end
      S_FLUSH: begin
        write_file = 1'b1;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_ERR: begin
        busy        = 1'b0;
        timeout_err = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_appr_mul_sequencer.sv
// tb_appr_mul_sequencer
// Directed bench for the approximate-multiplier stage sequencer. A small
// datapath responder answers each enable with its done after a programmable
// latency; a monitor counts output pulses and drives co for the last pair.

module tb_appr_mul_sequencer;

  localparam int TIMEOUT = 8;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_LZD   = 4'd2;
  localparam logic [3:0] S_ADD   = 4'd3;
  localparam logic [3:0] S_SHIFT = 4'd4;
  localparam logic [3:0] S_MUL   = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd10;
  localparam logic [3:0] S_ERR   = 4'd11;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic lzd_a_done = 1'b0, lzd_b_done = 1'b0, add_done = 1'b0;
  logic shift_a_done = 1'b0, shift_b_done = 1'b0, mul_done = 1'b0;
  logic r_shift_done = 1'b0, co = 1'b0;
  logic ld_a, ld_b, lzd_a_en, lzd_b_en, add_en, l_shift_a_en, l_shift_b_en;
  logic mul_en, r_shift_en, write_en, count_enable, write_file;
  logic busy, done, timeout_err;
  logic [3:0] dbg_state;

  appr_mul_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .lzd_a_done(lzd_a_done), .lzd_b_done(lzd_b_done), .add_done(add_done),
    .shift_a_done(shift_a_done), .shift_b_done(shift_b_done),
    .mul_done(mul_done), .r_shift_done(r_shift_done), .co(co),
    .ld_a(ld_a), .ld_b(ld_b), .lzd_a_en(lzd_a_en), .lzd_b_en(lzd_b_en),
    .add_en(add_en), .l_shift_a_en(l_shift_a_en), .l_shift_b_en(l_shift_b_en),
    .mul_en(mul_en), .r_shift_en(r_shift_en), .write_en(write_en),
    .count_enable(count_enable), .write_file(write_file),
    .busy(busy), .done(done), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  logic [14:0] all_outs;
  logic [11:0] all_ens;
  assign all_ens  = {ld_a, ld_b, lzd_a_en, lzd_b_en, add_en, l_shift_a_en,
                     l_shift_b_en, mul_en, r_shift_en, write_en, count_enable,
                     write_file};
  assign all_outs = {all_ens, busy, done, timeout_err};

  int n_checks = 0;
  int n_fail   = 0;

  // Responder latencies: done is sampled high in cycle E+lat, E = first
  // cycle the enable is high. A large value means the done never comes.
  int lat_la = 3, lat_lb = 3, lat_add = 3, lat_sa = 3, lat_sb = 3;
  int lat_mul = 3, lat_rs = 3;
  int c_la = 0, c_lb = 0, c_add = 0, c_sa = 0, c_sb = 0, c_mul = 0, c_rs = 0;

  always @(negedge clk) begin
    c_la  = lzd_a_en     ? c_la + 1  : 0;
    c_lb  = lzd_b_en     ? c_lb + 1  : 0;
    c_add = add_en       ? c_add + 1 : 0;
    c_sa  = l_shift_a_en ? c_sa + 1  : 0;
    c_sb  = l_shift_b_en ? c_sb + 1  : 0;
    c_mul = mul_en       ? c_mul + 1 : 0;
    c_rs  = r_shift_en   ? c_rs + 1  : 0;
    lzd_a_done   = (c_la  == lat_la + 1);
    lzd_b_done   = (c_lb  == lat_lb + 1);
    add_done     = (c_add == lat_add + 1);
    shift_a_done = (c_sa  == lat_sa + 1);
    shift_b_done = (c_sb  == lat_sb + 1);
    mul_done     = (c_mul == lat_mul + 1);
    r_shift_done = (c_rs  == lat_rs + 1);
  end

  // Pulse counters and pair counter model; co flags the last pair in NEXT.
  int n_ld = 0, n_wr = 0, n_ce = 0, n_wf = 0;
  int run_ld = 0;
  int npairs = 1;

  always @(negedge clk) begin
    if (ld_a) n_ld++;
    if (write_en) n_wr++;
    if (count_enable) n_ce++;
    if (write_file) n_wf++;
    if (!busy) run_ld = 0;
    else if (ld_a) run_ld++;
    co = count_enable && (run_ld == npairs);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dbg_state == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    tick();
    n_checks++;
    if (all_outs !== 15'd0) begin
      n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    n_checks++;
    if (dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
    end
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (dbg_state !== S_IDLE || all_outs !== 15'd0) begin
      n_fail++; $display("FAIL idle_hold: state %0d outs %h expected %0d / 0", dbg_state, all_outs, S_IDLE);
    end
  endtask

  task automatic test_single_pair();
    int ld0, wr0, ce0, wf0;
    bit ok;
    ld0 = n_ld; wr0 = n_wr; ce0 = n_ce; wf0 = n_wf;
    npairs = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (dbg_state !== S_LOAD || ld_a !== 1'b1 || ld_b !== 1'b1) begin
      n_fail++; $display("FAIL single_load: state %0d ld_a %b ld_b %b expected %0d 1 1", dbg_state, ld_a, ld_b, S_LOAD);
    end
    wait_state(S_DONE, 200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL single_reach_done: got state %0d expected %0d", dbg_state, S_DONE);
    end
    n_checks++;
    if ((n_ld - ld0) != 1 || (n_wr - wr0) != 1 || (n_ce - ce0) != 1 || (n_wf - wf0) != 1) begin
      n_fail++; $display("FAIL single_pulses: ld %0d wr %0d ce %0d wf %0d expected 1 1 1 1",
                         n_ld - ld0, n_wr - wr0, n_ce - ce0, n_wf - wf0);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL single_status: done %b busy %b err %b expected 1 0 0", done, busy, timeout_err);
    end
  endtask

  task automatic test_three_pairs();
    int ld0, wr0, ce0, wf0;
    bit ok;
    ld0 = n_ld; wr0 = n_wr; ce0 = n_ce; wf0 = n_wf;
    npairs = 3;
    lat_add = 1; lat_mul = 2; lat_rs = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(S_DONE, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL three_reach_done: got state %0d expected %0d", dbg_state, S_DONE);
    end
    n_checks++;
    if ((n_ld - ld0) != 3 || (n_wr - wr0) != 3 || (n_ce - ce0) != 3 || (n_wf - wf0) != 1) begin
      n_fail++; $display("FAIL three_pulses: ld %0d wr %0d ce %0d wf %0d expected 3 3 3 1",
                         n_ld - ld0, n_wr - wr0, n_ce - ce0, n_wf - wf0);
    end
    npairs = 1;
    lat_add = 3; lat_mul = 3; lat_rs = 3;
  endtask

  task automatic test_lzd_skew();
    bit ok;
    // B done in cycle E+2, A done in cycle E+7 (also the watchdog expiry cycle).
    lat_la = 7; lat_lb = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (dbg_state !== S_LZD || lzd_a_en !== 1'b1 || lzd_b_en !== 1'b1) begin
      n_fail++; $display("FAIL skew_entry: state %0d a_en %b b_en %b expected %0d 1 1", dbg_state, lzd_a_en, lzd_b_en, S_LZD);
    end
    repeat (3) tick();
    n_checks++;
    if (lzd_a_en !== 1'b1 || lzd_b_en !== 1'b0) begin
      n_fail++; $display("FAIL skew_b_drop: a_en %b b_en %b expected 1 0", lzd_a_en, lzd_b_en);
    end
    repeat (4) tick();
    n_checks++;
    if (dbg_state !== S_LZD || lzd_a_en !== 1'b1) begin
      n_fail++; $display("FAIL skew_a_hold: state %0d a_en %b expected %0d 1", dbg_state, lzd_a_en, S_LZD);
    end
    tick();
    n_checks++;
    if (dbg_state !== S_ADD || lzd_a_en !== 1'b0 || add_en !== 1'b1) begin
      n_fail++; $display("FAIL skew_to_add: state %0d a_en %b add_en %b expected %0d 0 1", dbg_state, lzd_a_en, add_en, S_ADD);
    end
    lat_la = 3; lat_lb = 3;
    wait_state(S_DONE, 200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL skew_reach_done: got state %0d expected %0d", dbg_state, S_DONE);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    lat_mul = 1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(S_MUL, 100, ok);
    n_checks++;
    if (!ok || mul_en !== 1'b1) begin
      n_fail++; $display("FAIL to_reach_mul: state %0d mul_en %b expected %0d 1", dbg_state, mul_en, S_MUL);
    end
    repeat (7) tick();
    n_checks++;
    if (dbg_state !== S_MUL || mul_en !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL to_last_wait: state %0d mul_en %b err %b expected %0d 1 0", dbg_state, mul_en, timeout_err, S_MUL);
    end
    tick();
    n_checks++;
    if (dbg_state !== S_ERR || timeout_err !== 1'b1 || all_ens !== 12'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_err: state %0d err %b ens %h busy %b expected %0d 1 0 0",
                         dbg_state, timeout_err, all_ens, busy, S_ERR);
    end
    lat_mul = 3;
    repeat (2) tick();
    n_checks++;
    if (dbg_state !== S_ERR || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL to_err_hold: state %0d err %b expected %0d 1", dbg_state, timeout_err, S_ERR);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (dbg_state !== S_LOAD || timeout_err !== 1'b0 || ld_a !== 1'b1) begin
      n_fail++; $display("FAIL to_restart: state %0d err %b ld_a %b expected %0d 0 1", dbg_state, timeout_err, ld_a, S_LOAD);
    end
    wait_state(S_DONE, 200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL to_recover_done: got state %0d expected %0d", dbg_state, S_DONE);
    end
  endtask

  task automatic test_reset_mid_run();
    int wf0;
    bit ok;
    wf0 = n_wf;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(S_SHIFT, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rst_reach_shift: got state %0d expected %0d", dbg_state, S_SHIFT);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== 15'd0 || dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL rst_async: outs %h state %0d expected 0 %0d", all_outs, dbg_state, S_IDLE);
    end
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ((n_wf - wf0) != 0 || dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL rst_no_flush: wf %0d state %0d expected 0 %0d", n_wf - wf0, dbg_state, S_IDLE);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (dbg_state !== S_LOAD || ld_a !== 1'b1) begin
      n_fail++; $display("FAIL rst_restart: state %0d ld_a %b expected %0d 1", dbg_state, ld_a, S_LOAD);
    end
    wait_state(S_DONE, 200, ok);
    n_checks++;
    if (!ok || (n_wf - wf0) != 1) begin
      n_fail++; $display("FAIL rst_rerun: state %0d wf %0d expected %0d 1", dbg_state, n_wf - wf0, S_DONE);
    end
  endtask

  task automatic test_back_to_back();
    int ld0, wf0;
    bit ok;
    ld0 = n_ld; wf0 = n_wf;
    start = 1'b1;
    tick();
    n_checks++;
    if (dbg_state !== S_LOAD) begin
      n_fail++; $display("FAIL b2b_first_load: got state %0d expected %0d", dbg_state, S_LOAD);
    end
    wait_state(S_DONE, 200, ok);
    n_checks++;
    if (!ok || done !== 1'b1 || (n_ld - ld0) != 1 || (n_wf - wf0) != 1) begin
      n_fail++; $display("FAIL b2b_first_run: state %0d done %b ld %0d wf %0d expected %0d 1 1 1",
                         dbg_state, done, n_ld - ld0, n_wf - wf0, S_DONE);
    end
    tick();
    n_checks++;
    if (dbg_state !== S_LOAD || ld_a !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_load: state %0d ld_a %b done %b expected %0d 1 0", dbg_state, ld_a, done, S_LOAD);
    end
    start = 1'b0;
    wait_state(S_DONE, 200, ok);
    n_checks++;
    if (!ok || (n_wf - wf0) != 2) begin
      n_fail++; $display("FAIL b2b_second_run: state %0d wf %0d expected %0d 2", dbg_state, n_wf - wf0, S_DONE);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_three_pairs();
    test_lzd_skew();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
